pc_fetch_unit: RTL and testbench

- Instruction-fetch stage of the CPU: PC register, next-PC selection and the IF/ID instruction register.
- Drives instruction memory and presents the fetched instruction to decode.
- Supplies `immediate_16` (`instr[15:0]`) to the sign/zero-extend stage.
- Consumes that stage's `immediate_32` to form branch targets.

---
 rtl/pc_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction-fetch stage: PC register, next-PC selection and the IF/ID
//   instruction register. Drives instruction memory (combinational read) and
//   hands the fetched instruction to decode.
//
//   Optional build macro: PC_FETCH_DELAY_SLOT_EN
//     defined   -> MIPS branch delay slot: on a redirect the instruction at PC
//                  is kept in IF/ID instead of being squashed.
//     undefined -> a redirect squashes the wrong-path fetch (1-cycle bubble).
//
// Ports
//   CLK           in   system clock, rising edge
//   Reset         in   asynchronous, active-high reset
//   PCWre         in   PC / IF-ID write enable (0 = stall)
//   PCSrc[1:0]    in   next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
//   Halt          in   halt request from decode
//   immediate_32  in   extended immediate (branch offset, in words)
//   addr_26       in   jump index field
//   rs_data       in   register value for jr
//   imem_rdata    in   instruction memory read data for imem_addr
//   imem_addr     out  instruction memory address (= PC)
//   PC            out  current fetch address
//   id_pc4        out  PC+4 of the instruction held in IF/ID
//   instr         out  IF/ID instruction register
//   instr_valid   out  instr holds a real instruction
//   immediate_16  out  instr[15:0], to the extend stage
//   halted        out  fetch is halted (only Reset exits)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic        Halt,
  input  logic [31:0] immediate_32,
  input  logic [25:0] addr_26,
  input  logic [31:0] rs_data,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [31:0] id_pc4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] immediate_16,
  output logic        halted
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_pc4;
  logic [31:0] r_instr;
  logic        r_valid;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_id_pc4_nxt;
  logic [31:0] w_instr_nxt;
  logic        w_valid_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_unused_rs_lo;

  assign w_pc_plus4 = r_pc + 32'd4;

  // A redirect only comes from a real instruction; bubbles cannot redirect.
  assign w_redirect = r_valid && (PCSrc != 2'b00);

  // jr target is word-aligned, so the low two bits of rs_data are dropped.
  assign w_unused_rs_lo = ^rs_data[1:0];

  always_comb begin
    w_target = w_pc_plus4;
    case (PCSrc)
      2'b01:   w_target = r_id_pc4 + (immediate_32 << 2);
      2'b10:   w_target = {r_id_pc4[31:28], addr_26, 2'b00};
      2'b11:   w_target = {rs_data[31:2], 2'b00};
      default: w_target = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_id_pc4_nxt = r_id_pc4;
    w_instr_nxt  = r_instr;
    w_valid_nxt  = r_valid;

    case (r_state)
      // First fetch after reset; stall and redirect inputs are meaningless yet.
      S_BOOT: begin
        w_instr_nxt  = imem_rdata;
        w_valid_nxt  = 1'b1;
        w_pc_nxt     = w_pc_plus4;
        w_id_pc4_nxt = w_pc_plus4;
        w_state_nxt  = S_RUN;
      end

      S_RUN: begin
        if (Halt) begin
          w_state_nxt = S_HALT;
          w_instr_nxt = NOP_INSTR;
          w_valid_nxt = 1'b0;
        end else if (PCWre) begin
          if (w_redirect) begin
            w_pc_nxt = w_target;
`ifdef PC_FETCH_DELAY_SLOT_EN
            // Delay slot: the instruction after the branch still executes.
            w_instr_nxt  = imem_rdata;
            w_valid_nxt  = 1'b1;
            w_id_pc4_nxt = w_pc_plus4;
`else
            // Squash the wrong-path fetch; id_pc4 is deliberately left alone.
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
`endif
          end else begin
            w_pc_nxt     = w_pc_plus4;
            w_instr_nxt  = imem_rdata;
            w_id_pc4_nxt = w_pc_plus4;
            w_valid_nxt  = 1'b1;
          end
        end
        // PCWre = 0: everything holds; decode re-presents any pending redirect.
      end

      S_HALT: begin
        w_state_nxt = S_HALT;
      end

      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC;
      r_id_pc4 <= RESET_PC;
      r_instr  <= NOP_INSTR;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_id_pc4 <= w_id_pc4_nxt;
      r_instr  <= w_instr_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign imem_addr    = r_pc;
  assign PC           = r_pc;
  assign id_pc4       = r_id_pc4;
  assign instr        = r_instr;
  assign instr_valid  = r_valid;
  assign immediate_16 = r_instr[15:0];
  assign halted       = (r_state == S_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Self-checking bench for pc_fetch_unit. A reference model advances on every
//   stimulus step and pushes the expected register image to a queue; after the
//   clock edge (or async reset) the image is popped and compared to the DUT.
//   Instruction memory is a pure function of the address.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] id_pc4;
    logic        valid;
    logic        halted;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre = 1'b1;
  logic [1:0]  PCSrc = 2'b00;
  logic        Halt = 1'b0;
  logic [31:0] immediate_32 = '0;
  logic [25:0] addr_26 = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] PC;
  logic [31:0] id_pc4;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] immediate_16;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Reference model state
  int          m_st;      // 0 boot, 1 run, 2 halt
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_id_pc4;
  logic        m_valid;

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) u_dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .PCWre       (PCWre),
    .PCSrc       (PCSrc),
    .Halt        (Halt),
    .immediate_32(immediate_32),
    .addr_26     (addr_26),
    .rs_data     (rs_data),
    .imem_rdata  (imem_rdata),
    .imem_addr   (imem_addr),
    .PC          (PC),
    .id_pc4      (id_pc4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .immediate_16(immediate_16),
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return {16'h3C00 ^ a[31:16], a[15:0] ^ 16'h0A50};
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_image();
    exp_t e;
    e.pc     = m_pc;
    e.instr  = m_instr;
    e.id_pc4 = m_id_pc4;
    e.valid  = m_valid;
    e.halted = (m_st == 2);
    return e;
  endfunction

  task automatic model_reset();
    m_st     = 0;
    m_pc     = 32'h0;
    m_id_pc4 = 32'h0;
    m_instr  = 32'h0;
    m_valid  = 1'b0;
  endtask

  // One rising edge of the reference model using the currently driven inputs.
  task automatic model_step();
    logic [31:0] fetched;
    logic [31:0] seq;
    logic [31:0] tgt;
    fetched = imem_word(m_pc);
    seq     = m_pc + 32'd4;
    if (m_st == 0) begin
      m_instr = fetched; m_valid = 1'b1; m_id_pc4 = seq; m_pc = seq; m_st = 1;
    end else if (m_st == 1) begin
      if (Halt) begin
        m_st = 2; m_instr = 32'h0; m_valid = 1'b0;
      end else if (PCWre) begin
        if (m_valid && PCSrc != 2'b00) begin
          if (PCSrc == 2'b01)      tgt = m_id_pc4 + {immediate_32[29:0], 2'b00};
          else if (PCSrc == 2'b10) tgt = {m_id_pc4[31:28], addr_26, 2'b00};
          else                     tgt = rs_data & 32'hFFFF_FFFC;
`ifdef PC_FETCH_DELAY_SLOT_EN
          m_instr = fetched; m_valid = 1'b1; m_id_pc4 = seq;
`else
          m_instr = 32'h0; m_valid = 1'b0;
`endif
          m_pc = tgt;
        end else begin
          m_instr = fetched; m_valid = 1'b1; m_id_pc4 = seq; m_pc = seq;
        end
      end
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".pc"},     PC,                      e.pc);
    check({tag, ".iaddr"},  imem_addr,               e.pc);
    check({tag, ".instr"},  instr,                   e.instr);
    check({tag, ".imm16"},  {16'h0, immediate_16},   {16'h0, e.instr[15:0]});
    check({tag, ".idpc4"},  id_pc4,                  e.id_pc4);
    check({tag, ".valid"},  {31'h0, instr_valid},    {31'h0, e.valid});
    check({tag, ".halted"}, {31'h0, halted},         {31'h0, e.halted});
  endtask

  task automatic tick(input string tag);
    model_step();
    exp_q.push_back(model_image());
    @(posedge CLK);
    #1;
    pop_check(tag);
  endtask

  // Assert reset between clock edges and check its effect before any edge.
  task automatic async_reset(input string tag);
    @(negedge CLK);
    #2;
    Reset = 1'b1;
    model_reset();
    exp_q.push_back(model_image());
    #1;
    pop_check(tag);
    check({tag, ".pc_now"}, PC, 32'h0);
    check({tag, ".halt_now"}, {31'h0, halted}, 32'h0);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    PCWre = 1'b1;
    PCSrc = 2'b00;
    Halt  = 1'b0;

    // Reset and boot
    async_reset("rst0");
    check("rst0.instr", instr, 32'h0);
    check("rst0.valid", {31'h0, instr_valid}, 32'h0);
    tick("boot");
    check("boot.pc", PC, 32'h4);
    check("boot.instr", instr, 32'h2001_0005);
    check("boot.valid", {31'h0, instr_valid}, 32'h1);
    check("boot.imm16", {16'h0, immediate_16}, 32'h0005);

    // Straight-line run
    for (int i = 2; i <= 4; i++) begin
      tick("seq");
      check("seq.pc", PC, 32'(4 * i));
      check("seq.idpc4", id_pc4, 32'(4 * i));
    end

    // Branch backwards from id_pc4 = 8 by -2 words
    async_reset("rst1");
    tick("boot1");
    tick("seq1");
    PCSrc = 2'b01;
    immediate_32 = 32'hFFFF_FFFE;
    tick("branch");
    check("branch.pc", PC, 32'h0);
`ifdef PC_FETCH_DELAY_SLOT_EN
    check("branch.valid", {31'h0, instr_valid}, 32'h1);
    check("branch.instr", instr, imem_word(32'h8));
`else
    check("branch.valid", {31'h0, instr_valid}, 32'h0);
    check("branch.instr", instr, 32'h0);
`endif
    tick("post_branch");
    check("post_branch.pc", PC, 32'h4);

    // jr to the high segment, then jump within it, then jr back
    PCSrc = 2'b11;
    rs_data = 32'h1000_0000;
    tick("jr_hi");
    check("jr_hi.pc", PC, 32'h1000_0000);
    PCSrc = 2'b00;
    tick("seq_hi");
    check("seq_hi.idpc4", id_pc4, 32'h1000_0004);
    PCSrc = 2'b10;
    addr_26 = 26'h000_0040;
    tick("jump");
    check("jump.pc", PC, 32'h1000_0100);
    PCSrc = 2'b00;
    tick("seq_j");
    PCSrc = 2'b11;
    rs_data = 32'h0000_0123;
    tick("jr");
    check("jr.pc", PC, 32'h0000_0120);
    PCSrc = 2'b00;
    tick("seq_jr");

    // Stall with a pending branch, then release
    PCWre = 1'b0;
    PCSrc = 2'b01;
    immediate_32 = 32'h0000_0004;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall.pc", PC, 32'h124);
      check("stall.instr", instr, imem_word(32'h120));
      check("stall.valid", {31'h0, instr_valid}, 32'h1);
    end
    PCWre = 1'b1;
    tick("stall_rel");
    check("stall_rel.pc", PC, 32'h134);
    PCSrc = 2'b00;
    tick("seq_s");

    // Halt, then frozen across 5 edges despite activity on the inputs
    Halt = 1'b1;
    tick("halt");
    check("halt.halted", {31'h0, halted}, 32'h1);
    Halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      PCSrc = 2'(i);
      PCWre = i[0];
      tick("frozen");
      check("frozen.pc", PC, 32'h138);
      check("frozen.halted", {31'h0, halted}, 32'h1);
    end
    PCWre = 1'b1;
    PCSrc = 2'b00;
    async_reset("rst_halt");

    // Wrap-around at the top of the address space
    tick("boot2");
    PCSrc = 2'b11;
    rs_data = 32'hFFFF_FFFF;
    tick("jr_top");
    check("jr_top.pc", PC, 32'hFFFF_FFFC);
    PCSrc = 2'b00;
    tick("wrap");
    check("wrap.pc", PC, 32'h0);
    check("wrap.idpc4", id_pc4, 32'h0);

    // Halt wins over a stall
    PCWre = 1'b0;
    Halt = 1'b1;
    tick("halt_stall");
    check("halt_stall.halted", {31'h0, halted}, 32'h1);
    Halt = 1'b0;
    PCWre = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
